// File: rtl/pkt_mbst_pkg.sv
// Shared types and constants for the multi-burst packet length counter.
// len_flags layout is {abort, runt, ovf, zero}.
package pkt_mbst_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StInPkt = 1'b1
    } state_e;

    localparam int unsigned FlagZero  = 0;
    localparam int unsigned FlagOvf   = 1;
    localparam int unsigned FlagRunt  = 2;
    localparam int unsigned FlagAbort = 3;
    localparam int unsigned NumFlags  = 4;

    function automatic logic [NumFlags-1:0] pack_flags(input logic f_abort, input logic f_runt,
                                                       input logic f_ovf, input logic f_zero);
        logic [NumFlags-1:0] f;
        f            = '0;
        f[FlagAbort] = f_abort;
        f[FlagRunt]  = f_runt;
        f[FlagOvf]   = f_ovf;
        f[FlagZero]  = f_zero;
        return f;
    endfunction

endpackage

// File: rtl/pkt_sat_cnt.sv
// Saturating statistics counter with synchronous clear; clear beats a same-cycle increment.
module pkt_sat_cnt #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pkt_mbst_len_cnt.sv
// Multi-burst packet length/XOR counter: one registered report per packet plus
// saturating packet, zero-frame and error statistics.
module pkt_mbst_len_cnt
    import pkt_mbst_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned MIN_LEN    = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  sop,
    input  logic                  eop,
    input  logic                  valid,
    input  logic                  zero,
    input  logic                  clr_stats,
    output logic                  len_vld,
    output logic [LEN_WIDTH-1:0]  len,
    output logic [DATA_WIDTH-1:0] len_xor,
    output logic [NumFlags-1:0]   len_flags,
    output logic                  in_pkt,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  zero_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam logic [LEN_WIDTH-1:0] LenOne = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] LenMax = '1;

    state_e                st_q, st_d;
    logic [LEN_WIDTH-1:0]  wc_q, wc_d, wc_inc;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  zf_q, zf_d, ovf_q, ovf_d, ovf_inc;
    logic                  orphan;

    // Primary report (normal end, abort or idle single-word) and the secondary
    // single-word report that can trail an abort in the same cycle.
    logic                  p_vld, s_vld;
    logic [LEN_WIDTH-1:0]  p_len;
    logic [DATA_WIDTH-1:0] p_xor, s_xor;
    logic [NumFlags-1:0]   p_flags, s_flags;

    logic                  pend_vld_q, pend_vld_d;
    logic [LEN_WIDTH-1:0]  pend_len_q, pend_len_d;
    logic [DATA_WIDTH-1:0] pend_xor_q, pend_xor_d;
    logic [NumFlags-1:0]   pend_flags_q, pend_flags_d;

    logic                  ld_vld;
    logic [LEN_WIDTH-1:0]  ld_len;
    logic [DATA_WIDTH-1:0] ld_xor;
    logic [NumFlags-1:0]   ld_flags;

    logic                  len_vld_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [DATA_WIDTH-1:0] len_xor_q;
    logic [NumFlags-1:0]   len_flags_q;

    logic                  pkt_inc, zero_inc, err_inc;

    function automatic logic is_runt(input logic [LEN_WIDTH-1:0] l, input logic z,
                                     input logic ab);
        return !z && !ab && (32'(l) < MIN_LEN);
    endfunction

    always_comb begin
        st_d    = st_q;
        wc_d    = wc_q;
        acc_d   = acc_q;
        zf_d    = zf_q;
        ovf_d   = ovf_q;
        orphan  = 1'b0;
        p_vld   = 1'b0;
        p_len   = '0;
        p_xor   = '0;
        p_flags = '0;
        s_vld   = 1'b0;
        s_xor   = '0;
        s_flags = '0;
        wc_inc  = (wc_q == LenMax) ? wc_q : wc_q + LenOne;
        ovf_inc = ovf_q | (wc_q == LenMax);
        // Nothing touches data unless valid, so gap-cycle X never reaches the accumulator.
        if (valid) begin
            unique case (st_q)
                StIdle: begin
                    if (!sop) begin
                        orphan = 1'b1;
                    end else if (eop) begin
                        p_vld   = 1'b1;
                        p_len   = LenOne;
                        p_xor   = data;
                        p_flags = pack_flags(1'b0, is_runt(LenOne, zero, 1'b0), 1'b0, zero);
                    end else begin
                        st_d  = StInPkt;
                        wc_d  = LenOne;
                        acc_d = data;
                        zf_d  = zero;
                        ovf_d = 1'b0;
                    end
                end
                StInPkt: begin
                    if (sop) begin
                        p_vld   = 1'b1;
                        p_len   = wc_q;
                        p_xor   = acc_q;
                        p_flags = pack_flags(1'b1, 1'b0, ovf_q, zf_q);
                        if (eop) begin
                            s_vld   = 1'b1;
                            s_xor   = data;
                            s_flags = pack_flags(1'b0, is_runt(LenOne, zero, 1'b0), 1'b0, zero);
                            st_d    = StIdle;
                        end else begin
                            wc_d  = LenOne;
                            acc_d = data;
                            zf_d  = zero;
                            ovf_d = 1'b0;
                        end
                    end else if (eop) begin
                        p_vld   = 1'b1;
                        p_len   = wc_inc;
                        p_xor   = acc_q ^ data;
                        p_flags = pack_flags(1'b0, is_runt(wc_inc, zf_q, 1'b0), ovf_inc, zf_q);
                        st_d    = StIdle;
                    end else begin
                        wc_d  = wc_inc;
                        acc_d = acc_q ^ data;
                        ovf_d = ovf_inc;
                    end
                end
                default: st_d = StIdle;
            endcase
        end
    end

    // A pending report always goes out first. It can only coexist with a new
    // primary report while idle, never with an abort pair, so one slot is enough.
    always_comb begin
        ld_vld       = pend_vld_q;
        ld_len       = pend_len_q;
        ld_xor       = pend_xor_q;
        ld_flags     = pend_flags_q;
        pend_vld_d   = 1'b0;
        pend_len_d   = pend_len_q;
        pend_xor_d   = pend_xor_q;
        pend_flags_d = pend_flags_q;
        if (pend_vld_q) begin
            if (p_vld) begin
                pend_vld_d   = 1'b1;
                pend_len_d   = p_len;
                pend_xor_d   = p_xor;
                pend_flags_d = p_flags;
            end
        end else begin
            ld_vld   = p_vld;
            ld_len   = p_len;
            ld_xor   = p_xor;
            ld_flags = p_flags;
            if (s_vld) begin
                pend_vld_d   = 1'b1;
                pend_len_d   = LenOne;
                pend_xor_d   = s_xor;
                pend_flags_d = s_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= StIdle;
            wc_q         <= '0;
            acc_q        <= '0;
            zf_q         <= 1'b0;
            ovf_q        <= 1'b0;
            pend_vld_q   <= 1'b0;
            pend_len_q   <= '0;
            pend_xor_q   <= '0;
            pend_flags_q <= '0;
            len_vld_q    <= 1'b0;
            len_q        <= '0;
            len_xor_q    <= '0;
            len_flags_q  <= '0;
        end else begin
            st_q         <= st_d;
            wc_q         <= wc_d;
            acc_q        <= acc_d;
            zf_q         <= zf_d;
            ovf_q        <= ovf_d;
            pend_vld_q   <= pend_vld_d;
            pend_len_q   <= pend_len_d;
            pend_xor_q   <= pend_xor_d;
            pend_flags_q <= pend_flags_d;
            len_vld_q    <= ld_vld;
            if (ld_vld) begin
                len_q       <= ld_len;
                len_xor_q   <= ld_xor;
                len_flags_q <= ld_flags;
            end
        end
    end

    assign len_vld   = len_vld_q;
    assign len       = len_q;
    assign len_xor   = len_xor_q;
    assign len_flags = len_flags_q;
    assign in_pkt    = (st_q == StInPkt);

    // Counters advance with the report load so they line up with len_vld.
    assign pkt_inc  = ld_vld;
    assign zero_inc = ld_vld & ld_flags[FlagZero];
    assign err_inc  = orphan |
                      (ld_vld & (ld_flags[FlagAbort] | ld_flags[FlagRunt] | ld_flags[FlagOvf]));

    pkt_sat_cnt #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (pkt_inc),
        .cnt (pkt_cnt)
    );

    pkt_sat_cnt #(.WIDTH(CNT_WIDTH)) u_zero_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (zero_inc),
        .cnt (zero_cnt)
    );

    pkt_sat_cnt #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (err_inc),
        .cnt (err_cnt)
    );

endmodule

// File: doc/pkt_mbst_len_cnt.md
PKT_MBST_LEN_CNT -- requirements
Module: pkt_mbst_len_cnt

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of data bus.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, width of packet length result.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, width of statistics counters.
REQ-004 SHALL have parameter MIN_LEN, default 7, minimum legal non-zero packet length in valid words.
REQ-005 SHALL have one clock and one reset: clk  input  1  sole clock; rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have data  input  DATA_WIDTH  packet word.
REQ-007 SHALL have sop, eop, valid, zero  input  1 each  packet delimiters, word qualifier, zero-frame marker.
REQ-008 SHALL have clr_stats  input  1  synchronous clear of statistics counters.
REQ-009 SHALL have len_vld  output  1  one-cycle strobe, result fields valid.
REQ-010 SHALL have len  output  LEN_WIDTH  packet length in valid words.
REQ-011 SHALL have len_xor  output  DATA_WIDTH  XOR of all valid data words in the packet.
REQ-012 SHALL have len_flags  output  4  {abort, runt, ovf, zero}, qualified by len_vld.
REQ-013 SHALL have in_pkt  output  1  high while in IN_PKT state.
REQ-014 SHALL have pkt_cnt, zero_cnt, err_cnt  output  CNT_WIDTH each  saturating statistics.

Function
REQ-015 SHALL sample sop, eop, zero and data only when valid=1; cycles with valid=0 are multi-burst gaps, and all state holds.
REQ-016 SHALL implement FSM with states IDLE and IN_PKT.
REQ-017 IDLE, valid&sop&eop: single-word packet; report len=1, stay IDLE.
REQ-018 IDLE, valid&sop&~eop: go IN_PKT; word count=1; xor=data.
REQ-019 IDLE, valid&~sop: orphan word or EOP; increment err_cnt, no report, stay IDLE.
REQ-020 IN_PKT, valid&~sop&~eop: count+1, xor^=data.
REQ-021 IN_PKT, valid&eop&~sop: report len=count+1, xor including data; go IDLE.
REQ-022 IN_PKT, valid&sop: report the open packet with abort=1 and increment err_cnt; then handle the new SOP exactly as REQ-017/REQ-018 in the same cycle.
REQ-023 Report outputs (len_vld, len, len_xor, len_flags) SHALL be registered, with len_vld asserted exactly one cycle after the terminating word.
REQ-024 When REQ-022 and REQ-017 coincide, the abort report SHALL take precedence and the single-word report SHALL follow on the next cycle; one pending-report register suffices.
REQ-025 zero flag SHALL equal zero sampled on the SOP word; zero frames increment zero_cnt and never set runt.
REQ-026 runt SHALL be set when a non-zero, non-aborted packet has len<MIN_LEN; runt increments err_cnt.
REQ-027 Word count SHALL saturate at 2^LEN_WIDTH-1 and set ovf; ovf increments err_cnt.
REQ-028 pkt_cnt SHALL increment on every len_vld, including aborted packets.
REQ-029 Each counter increments by at most 1 per cycle; multiple error causes in one report count once.
REQ-030 All counters SHALL saturate at all-ones without wrapping.
REQ-031 clr_stats SHALL zero all counters next cycle; a simultaneous increment is discarded.
REQ-032 data SHALL be ignored when valid=0; X on data with valid=0 SHALL NOT propagate into len_xor.

Reset
REQ-033 rst SHALL force: FSM=IDLE, count=0, xor=0, pending report cleared, len_vld=0, len=0, len_xor=0, len_flags=0, in_pkt=0, all counters=0.
REQ-034 A packet open at reset SHALL be discarded silently, with no report and no error count.
REQ-035 rst SHALL take precedence over clr_stats and all inputs.

Structure
REQ-036 FSM state enum and len_flags bit-index constants SHALL live in shared package pkt_mbst_pkg.
REQ-037 Saturating counter SHALL be sub-module pkt_sat_cnt (params WIDTH; ports clk, rst, clr, inc, cnt), instantiated three times.

Verification
REQ-038 Packet of 10 words, data 0x01..0x0A, with a 3-cycle valid gap after word 4 -> one cycle after EOP: len_vld=1, len=10, len_xor=0x0B, flags=0, pkt_cnt=1.
REQ-039 sop&eop&zero&valid single cycle -> len=1, flags=zero, zero_cnt=1, err_cnt=0.
REQ-040 SOP, 3 words, then sop&eop -> abort report len=4, next cycle single-word report len=1; err_cnt=1 (the single-word packet, zero=0, is also a runt; err_cnt=2 total), pkt_cnt=2.
REQ-041 eop with valid while IDLE -> no len_vld, err_cnt=1.
REQ-042 LEN_WIDTH=4, 20-word packet -> len=15, ovf=1; also clr_stats asserted with a concurrent report -> all counters 0.
REQ-043 rst asserted mid-packet, then a 7-word packet -> exactly one report, len=7, flags=0, pkt_cnt=1.
